pad_serializer: RTL and testbench

PAD_SERIALIZER -- requirements
Module: pad_serializer

---
 rtl/pad_serializer_pkg.sv | 22 ++
 rtl/pad_shift_channel.sv | 41 ++++
 rtl/pad_serializer.sv | 61 ++++++
 tb/tb_pad_serializer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pad_serializer_pkg.sv
// Shared pad emulation definitions: default read length and SNES
// button bit positions within each pad's pad_btn slice.
package pad_serializer_pkg;

  localparam int SHIFT_LENGTH_DEF = 16;

  typedef enum int {
    BTN_B      = 0,
    BTN_Y      = 1,
    BTN_SELECT = 2,
    BTN_START  = 3,
    BTN_UP     = 4,
    BTN_DOWN   = 5,
    BTN_LEFT   = 6,
    BTN_RIGHT  = 7,
    BTN_A      = 8,
    BTN_X      = 9,
    BTN_L      = 10,
    BTN_R      = 11
  } snes_btn_e;

endpackage

// File: rtl/pad_shift_channel.sv
// One emulated pad: active-low shift register loaded on latch,
// shifted on accepted console clock rises.
module pad_shift_channel
  import pad_serializer_pkg::*;
#(
  parameter int BUTTON_COUNT = 12,
  parameter int SHIFT_LENGTH = SHIFT_LENGTH_DEF,
  parameter bit CONNECTED    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUTTON_COUNT-1:0] btn,
  input  logic                    load,
  input  logic                    shift,
  output logic                    out
);

  logic [SHIFT_LENGTH-1:0] sr;
  logic [SHIFT_LENGTH-1:0] load_val;

  // Unused trailing bits read back as released
  always_comb begin
    load_val                   = '1;
    load_val[BUTTON_COUNT-1:0] = ~btn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= CONNECTED ? '1 : '0;
    end else if (!CONNECTED) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_val;
    end else if (shift) begin
      sr <= {1'b1, sr[SHIFT_LENGTH-1:1]};
    end
  end

  assign out = sr[0];

endmodule

// File: rtl/pad_serializer.sv
// Console pad serializer: shared clock-edge detect and bit counter,
// one shift channel per emulated pad.
module pad_serializer
  import pad_serializer_pkg::*;
#(
  parameter int PAD_COUNT    = 2,
  parameter int BUTTON_COUNT = 12,
  parameter int SHIFT_LENGTH = SHIFT_LENGTH_DEF,
  parameter logic [PAD_COUNT-1:0] PAD_CONNECTED = '1,
  localparam int CW = $clog2(SHIFT_LENGTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PAD_COUNT*BUTTON_COUNT-1:0] pad_btn,
  input  logic                              pad_latch,
  input  logic                              pad_clk,
  output logic [PAD_COUNT-1:0]              pad_out,
  output logic [CW-1:0]                     shift_count,
  output logic                              read_done
);

  logic pad_clk_r;
  logic rise;
  logic shift;

  assign rise  = pad_clk & ~pad_clk_r;
  assign shift = rise & ~pad_latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      pad_clk_r   <= 1'b1;
      shift_count <= '0;
      read_done   <= 1'b0;
    end else begin
      pad_clk_r <= pad_clk;
      read_done <= 1'b0;
      if (pad_latch) begin
        shift_count <= '0;
      end else if (shift && shift_count != CW'(SHIFT_LENGTH)) begin
        shift_count <= shift_count + 1'b1;
        read_done   <= (shift_count == CW'(SHIFT_LENGTH - 1));
      end
    end
  end

  for (genvar p = 0; p < PAD_COUNT; p++) begin : g_pad
    pad_shift_channel #(
      .BUTTON_COUNT(BUTTON_COUNT),
      .SHIFT_LENGTH(SHIFT_LENGTH),
      .CONNECTED   (PAD_CONNECTED[p])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .btn  (pad_btn[p*BUTTON_COUNT +: BUTTON_COUNT]),
      .load (pad_latch),
      .shift(shift),
      .out  (pad_out[p])
    );
  end

endmodule

// File: tb/tb_pad_serializer.sv
// Directed bench for pad_serializer with pad 1 disconnected.
module tb_pad_serializer;
  import pad_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] pad_btn;
  logic        pad_latch;
  logic        pad_clk;
  logic [1:0]  pad_out;
  logic [4:0]  shift_count;
  logic        read_done;

  int n_checks = 0;
  int n_fail   = 0;
  int dones    = 0;
  int bad_p1   = 0;

  always #5 clk = ~clk;

  pad_serializer #(
    .PAD_COUNT    (2),
    .BUTTON_COUNT (12),
    .SHIFT_LENGTH (16),
    .PAD_CONNECTED(2'b01)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pad_btn    (pad_btn),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .pad_out    (pad_out),
    .shift_count(shift_count),
    .read_done  (read_done)
  );

  always @(negedge clk)
    if (reset === 1'b0 && pad_out[1] !== 1'b0) bad_p1++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch();
    pad_latch = 1'b1;
    tick();
    pad_latch = 1'b0;
  endtask

  task automatic rise();
    pad_clk = 1'b0;
    tick();
    pad_clk = 1'b1;
    tick();
    if (read_done) dones++;
  endtask

  initial begin
    logic [15:0] got;
    reset     = 1'b1;
    pad_btn   = '0;
    pad_latch = 1'b0;
    pad_clk   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_out", 32'(pad_out), 32'h1);
    check("reset_cnt", 32'(shift_count), 32'h0);
    check("reset_done", 32'(read_done), 32'h0);

    // Full read, pad0 B pressed
    pad_btn = 24'h001 | (24'h1 << (12 + BTN_A));
    latch();
    check("latch_cnt", 32'(shift_count), 32'h0);
    got    = '0;
    got[0] = pad_out[0];
    dones  = 0;
    for (int i = 1; i < 16; i++) begin
      rise();
      got[i] = pad_out[0];
    end
    check("done_before16", 32'(dones), 32'h0);
    rise();
    check("done_on16", 32'(read_done), 32'h1);
    check("bits_read", 32'(got), 32'hFFFE);
    check("cnt16", 32'(shift_count), 32'd16);
    check("p1_low", 32'(pad_out[1]), 32'h0);
    for (int i = 17; i <= 20; i++) begin
      rise();
      check("over_out", 32'(pad_out[0]), 32'h1);
    end
    check("sat_cnt", 32'(shift_count), 32'd16);
    check("done_once", 32'(dones), 32'h1);

    // Latch and rise in the same cycle: load wins
    latch();
    rise();
    rise();
    rise();
    check("pre_cnt", 32'(shift_count), 32'd3);
    pad_clk = 1'b0;
    tick();
    pad_clk   = 1'b1;
    pad_latch = 1'b1;
    tick();
    pad_latch = 1'b0;
    check("coinc_cnt", 32'(shift_count), 32'h0);
    check("coinc_out", 32'(pad_out[0]), 32'h0);
    tick();
    check("coinc_hold", 32'(pad_out[0]), 32'h0);

    // Button change mid-read ignored
    pad_btn = 24'h800;
    latch();
    for (int i = 1; i <= 5; i++) rise();
    pad_btn = 24'h000;
    for (int i = 6; i <= 10; i++) rise();
    check("bit10", 32'(pad_out[0]), 32'h1);
    rise();
    check("bit11", 32'(pad_out[0]), 32'h0);

    // Reset mid-read aborts
    pad_btn = 24'h001;
    latch();
    dones = 0;
    for (int i = 1; i <= 5; i++) rise();
    check("mid_cnt", 32'(shift_count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_cnt", 32'(shift_count), 32'h0);
    check("abort_out", 32'(pad_out), 32'h1);
    for (int i = 6; i <= 16; i++) rise();
    check("abort_nodone", 32'(dones), 32'h0);

    // Reset beats latch
    pad_latch = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    pad_latch = 1'b0;
    check("rst_prio", 32'(pad_out[0]), 32'h1);

    check("p1_always_low", 32'(bad_p1), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
